// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM encoding, keyboard command bytes
// and the frame parity helper.
package ps2_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_REQ     = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  // PS/2 frames carry odd parity over the eight data bits
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and status bundle between a PS/2 host transmitter and
// its client logic.
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic       busy;

  modport master (output tx_data, tx_valid, input tx_ready, tx_done, tx_err, busy);
  modport slave  (input tx_data, tx_valid, output tx_ready, tx_done, tx_err, busy);

endinterface

// File: rtl/ps2_line_sync.sv
// Brings one open-drain PS/2 line into the clk domain and flags its
// falling edges (previous synced value 1, current 0).
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic sync,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // two synchronizer flops plus one history flop; idle bus level is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
      prev_r <= 1'b1;
    end else begin
      meta_r <= pin;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign sync = sync_r;
  assign fall = prev_r & ~sync_r;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, frame
// shifted on device clock falls, ACK check. Define PS2_TX_TIMEOUT_EN for a watchdog.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  bus,
  inout  wire           PS2_CLK,
  inout  wire           PS2_DATA
);

  localparam int               INH_W    = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_DATA = INH_W'(INHIBIT_CYCLES - 2);

  logic [2:0]       state_r;
  logic [9:0]       frame_r;
  logic [3:0]       bit_cnt_r;
  logic [INH_W-1:0] inh_cnt_r;
  logic             clk_low_r;
  logic             data_low_r;
  logic             tx_done_r;
  logic             tx_err_r;
  logic             clk_fall_s;
  logic             data_sync_s;
  logic             timeout_s;
  logic             unused_clk_sync_s;
  logic             unused_data_fall_s;

  ps2_line_sync u_clk_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (PS2_CLK),
    .sync (unused_clk_sync_s),
    .fall (clk_fall_s)
  );

  ps2_line_sync u_data_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (PS2_DATA),
    .sync (data_sync_s),
    .fall (unused_data_fall_s)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wdog_r;

  // watchdog restarts in IDLE and counts every cycle of a transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_r <= '0;
    end else if (state_r == ST_IDLE) begin
      wdog_r <= '0;
    end else begin
      wdog_r <= wdog_r + WD_W'(1);
    end
  end

  assign timeout_s = (state_r != ST_IDLE) && (wdog_r == WD_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // frame sequencer; frame_r holds {stop, parity, data} indexed by bit_cnt_r
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      frame_r    <= '0;
      bit_cnt_r  <= 4'd0;
      inh_cnt_r  <= '0;
      clk_low_r  <= 1'b0;
      data_low_r <= 1'b0;
      tx_done_r  <= 1'b0;
      tx_err_r   <= 1'b0;
    end else begin
      tx_done_r <= 1'b0;
      tx_err_r  <= 1'b0;
      if (timeout_s) begin
        state_r    <= ST_IDLE;
        clk_low_r  <= 1'b0;
        data_low_r <= 1'b0;
        tx_err_r   <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            clk_low_r  <= 1'b0;
            data_low_r <= 1'b0;
            if (bus.tx_valid) begin
              frame_r   <= {1'b1, odd_parity(bus.tx_data), bus.tx_data};
              bit_cnt_r <= 4'd0;
              inh_cnt_r <= '0;
              clk_low_r <= 1'b1;
              state_r   <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            inh_cnt_r <= inh_cnt_r + INH_W'(1);
            if (inh_cnt_r == INH_DATA) begin
              data_low_r <= 1'b1;
            end
            if (inh_cnt_r == INH_LAST) begin
              clk_low_r <= 1'b0;
              state_r   <= ST_REQ;
            end
          end
          ST_REQ: begin
            if (clk_fall_s) begin
              data_low_r <= ~frame_r[0];
              bit_cnt_r  <= 4'd1;
              state_r    <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (clk_fall_s) begin
              data_low_r <= ~frame_r[bit_cnt_r];
              bit_cnt_r  <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd9) begin
                state_r <= ST_ACK;
              end
            end
          end
          ST_ACK: begin
            if (clk_fall_s) begin
              if (data_sync_s) begin
                tx_err_r <= 1'b1;
              end else begin
                tx_done_r <= 1'b1;
              end
              state_r <= ST_IDLE;
            end
          end
          default: begin
            state_r    <= ST_IDLE;
            clk_low_r  <= 1'b0;
            data_low_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign PS2_CLK      = clk_low_r  ? 1'b0 : 1'bz;
  assign PS2_DATA     = data_low_r ? 1'b0 : 1'bz;
  assign bus.tx_ready = (state_r == ST_IDLE);
  assign bus.busy     = (state_r != ST_IDLE);
  assign bus.tx_done  = tx_done_r;
  assign bus.tx_err   = tx_err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a keyboard model clocks frames and
// compares them against byte/parity/stop rules; one process checks status every cycle.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 200;
  localparam int TO   = 3000;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  wire  ps2_clk;
  wire  ps2_data;

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

  ps2_host_tx_if bus ();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .PS2_CLK  (ps2_clk),
    .PS2_DATA (ps2_data)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int err_cnt     = 0;
  bit in_flight_m = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle status check: ready/busy follow the model's in-flight flag,
  // pulses are exclusive and only end an in-flight transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_ready", bus.tx_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_pulses", {bus.tx_done, bus.tx_err}, 0);
        in_flight_m = 1'b0;
      end else if (bus.tx_done || bus.tx_err) begin
        check("pulse_exclusive", bus.tx_done & bus.tx_err, 0);
        check("pulse_in_flight", in_flight_m, 1);
        if (bus.tx_done) done_cnt++;
        if (bus.tx_err) err_cnt++;
        in_flight_m = 1'b0;
      end else begin
        check("ready", bus.tx_ready, !in_flight_m);
        check("busy", bus.busy, in_flight_m);
        if (bus.tx_valid && !in_flight_m) in_flight_m = 1'b1;
      end
    end
  end

  // One device clock pulse; the line is sampled just before the clock rises.
  task automatic dev_pulse(input bit pre_ack, output logic sampled);
    repeat (HALF) @(negedge clk);
    if (pre_ack) begin
      dev_data_low = 1'b1;
      repeat (5) @(negedge clk);
    end
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    sampled = ps2_data;
    dev_clk_low = 1'b0;
  endtask

  task automatic handshake(input logic [7:0] d, input bit hold);
    @(posedge clk); #1;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(posedge clk); #1;
    if (hold) bus.tx_data = CMD_ENABLE;
    else      bus.tx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit ack, input bit hold,
                      input bit pin, input logic [9:0] lit);
    logic [9:0] exp_f;
    logic [9:0] got_f;
    logic       last_d;
    logic       prev_d;
    logic       s;
    int         cnt;
    int         d0;
    int         e0;
    int         guard;
    exp_f = {1'b1, ~^d, d};
    if (pin) check("model_frame", exp_f, lit);
    d0 = done_cnt;
    e0 = err_cnt;
    got_f = '0;
    handshake(d, hold);
    cnt = 0; prev_d = 1'b1; last_d = 1'b1;
    @(negedge clk);
    while (ps2_clk === 1'b0 && cnt < INH + 50) begin
      prev_d = last_d;
      last_d = ps2_data;
      cnt++;
      @(negedge clk);
    end
    check("inhibit_len", cnt, INH);
    check("inhibit_data_last", last_d, 0);
    check("inhibit_data_prev", prev_d, 1);
    check("start_bit", ps2_data, 0);
    for (int k = 1; k <= 11; k++) begin
      dev_pulse(k == 11 && ack, s);
      if (k <= 10) got_f[k-1] = s;
      if (k == 10 && hold) bus.tx_valid = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    dev_data_low = 1'b0;
    guard = 0;
    while (done_cnt == d0 && err_cnt == e0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    check("frame", got_f, exp_f);
    if (pin) check("frame_literal", got_f, lit);
    check("done_pulses", done_cnt - d0, ack ? 1 : 0);
    check("err_pulses", err_cnt - e0, ack ? 0 : 1);
    check("ready_after", bus.tx_ready, 1);
  endtask

  task automatic reset_mid();
    logic s;
    int d0;
    int e0;
    d0 = done_cnt;
    e0 = err_cnt;
    handshake(8'h00, 1'b0);
    repeat (INH + 10) @(negedge clk);
    for (int k = 1; k <= 4; k++) dev_pulse(1'b0, s);
    repeat (5) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    check("pre_rst_data", ps2_data, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_clk_released", ps2_clk, 1);
    check("rst_data_released", ps2_data, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_no_err", err_cnt - e0, 0);
    check("rst_idle", bus.tx_ready, 1);
  endtask

  task automatic timeout_test();
    int e0;
    int n;
    e0 = err_cnt;
    handshake(CMD_RESET, 1'b0);
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.tx_err !== 1'b1 && n < TO + 50);
    check("timeout_cycle", n, TO);
    @(negedge clk);
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_clk_released", ps2_clk, 1);
    check("timeout_data_released", ps2_data, 1);
    check("timeout_ready", bus.tx_ready, 1);
`else
    n = TO + 200;
    repeat (n) @(negedge clk);
    check("no_timeout_err", err_cnt - e0, 0);
    check("still_busy", bus.busy, 1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("recover_ready", bus.tx_ready, 1);
`endif
  endtask

  initial begin
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", bus.tx_ready, 1);
    check("reset_clk_line", ps2_clk, 1);
    check("reset_data_line", ps2_data, 1);
    send(CMD_SET_LED, 1'b1, 1'b0, 1'b1, 10'h3ED);
    send(8'h01, 1'b1, 1'b0, 1'b1, 10'h201);
    send(8'hFF, 1'b1, 1'b0, 1'b1, 10'h3FF);
    send(8'h5A, 1'b0, 1'b0, 1'b0, 10'h000);
    send(8'h3C, 1'b1, 1'b1, 1'b0, 10'h000);
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), 1'b0, 1'b0, 10'h000);
    end
    reset_mid();
    timeout_test();
    send(CMD_ENABLE, 1'b1, 1'b0, 1'b0, 10'h000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL bench_timeout: got running expected finished");
    $fatal(1, "bench did not complete in time");
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
- REQ-001 SHALL have parameter INHIBIT_CYCLES, default 12000: clk cycles PS2_CLK is held low before the start bit (120 us at 100 MHz).
- REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000: watchdog limit, in clk cycles, per transfer (20 ms at 100 MHz).
- REQ-003 clk  input  1  system clock; the only clock.
- REQ-004 rst  input  1  asynchronous, active-high reset.
- REQ-005 PS2_CLK  inout  1  open-drain PS/2 clock line: driven 1'b0 or 1'bz, never 1'b1.
- REQ-006 PS2_DATA  inout  1  open-drain PS/2 data line: driven 1'b0 or 1'bz, never 1'b1.
- REQ-007 tx_data  input  8  command byte to send to the keyboard.
- REQ-008 tx_valid  input  1  request to send; tx_data is captured when tx_valid && tx_ready.
- REQ-009 tx_ready  output  1  high only in IDLE.
- REQ-010 tx_done  output  1  one-cycle pulse when the device acknowledges.
- REQ-011 tx_err  output  1  one-cycle pulse on missing ACK or timeout.
- REQ-012 busy  output  1  high in every state except IDLE; the receive path uses it to ignore bus activity during transmit.

Function
- REQ-013 SHALL sample PS2_CLK and PS2_DATA through 2-FF synchronizers; a falling edge is synced-clk previous 1, current 0.
- REQ-014 States: IDLE, INHIBIT, REQ, SHIFT, ACK.
- REQ-015 IDLE: both lines released; on handshake, latch tx_data, compute odd parity (parity = ~^tx_data), go to INHIBIT.
- REQ-016 INHIBIT: PS2_CLK pulled low for exactly INHIBIT_CYCLES cycles; PS2_DATA pulled low in the last cycle; then go to REQ.
- REQ-017 REQ: release PS2_CLK; keep PS2_DATA low (start bit); on the first falling edge, present bit0 and go to SHIFT.
- REQ-018 SHIFT: on each later falling edge, present the next frame bit in order bit1..bit7, parity, stop.
- REQ-019 Presenting a 0 pulls PS2_DATA low; presenting a 1 releases it; the stop bit is a release.
- REQ-020 SHIFT: after the stop bit is presented (10th falling edge), go to ACK.
- REQ-021 ACK: on the 11th falling edge, sample synced PS2_DATA; if 0, pulse tx_done; if 1, pulse tx_err. Either way, return to IDLE.
- REQ-022 tx_done and tx_err SHALL never be asserted in the same cycle.
- REQ-023 tx_valid while busy SHALL be ignored; there is no queueing.
- REQ-024 Bit counter: 4 bits, reset to 0 on leaving IDLE; it SHALL NOT wrap within a frame.

Reset
- REQ-025 rst SHALL immediately, at any time, release both lines and force IDLE.
- REQ-026 rst SHALL clear tx_done, tx_err, busy, the bit counter and the watchdog; tx_ready is 1 after reset.
- REQ-027 Reset mid-frame SHALL NOT generate tx_done or tx_err.

Configuration
- REQ-028 Macro PS2_TX_TIMEOUT_EN defined: a watchdog counts from leaving IDLE; at TIMEOUT_CYCLES it releases both lines, pulses tx_err and returns to IDLE.
- REQ-029 Macro PS2_TX_TIMEOUT_EN undefined: no watchdog logic; a silent device leaves the block in REQ/SHIFT until rst.

Structure
- REQ-030 Shared package ps2_pkg SHALL hold the state encoding and command constants: CMD_SET_LED 8'hED, CMD_ENABLE 8'hF4, CMD_RESET 8'hFF, RSP_ACK 8'hFA.
- REQ-031 One sub-module, ps2_line_sync, SHALL contain the 2-FF synchronizer and the falling-edge detector; one instance per line.

Verification
- REQ-032 Send 8'hED, device model clocks and ACKs -> CLK held low 12000 cycles; DATA frame 0,1,0,1,1,0,1,1,1, parity 1, stop 1; one tx_done pulse.
- REQ-033 Send 8'h01 -> parity bit 0; send 8'hFF -> parity bit 1; each gives tx_done.
- REQ-034 Device model leaves DATA high on the 11th edge -> one tx_err pulse, no tx_done, tx_ready=1 the next cycle.
- REQ-035 tx_valid held with 8'hF4 while busy -> ignored; the in-flight byte is unchanged on the bus.
- REQ-036 Assert rst in SHIFT after bit 3 -> both lines are Z in the same cycle, IDLE, no pulses.
- REQ-037 With PS2_TX_TIMEOUT_EN defined, device never clocks -> tx_err at cycle 2000000 after the handshake; without the macro, no tx_err.
